// File: rtl/common_pkg.sv
// Shared geometry of the register file and ALU tree, plus calendar depth derivation.
package common_pkg;

   localparam int unsigned N_BANKS    = 8;
   localparam int unsigned TREE_DEPTH = 3;
   localparam int unsigned SEL_W      = $clog2(TREE_DEPTH + 1);

   // Deepest lookahead any descriptor can need, which bounds the calendar.
   function automatic int unsigned cal_depth(input int unsigned mem_lat,
                                             input int unsigned xbar_lat,
                                             input int unsigned alu_lat_per_lvl);
      int unsigned d;
      d = mem_lat;
      if (xbar_lat > d) d = xbar_lat;
      if (alu_lat_per_lvl * TREE_DEPTH > d) d = alu_lat_per_lvl * TREE_DEPTH;
      return d;
   endfunction

endpackage

// File: rtl/instr_decd_pkg.sv
// Write-back descriptor types and default pipeline latencies seen by the decoder.
package instr_decd_pkg;

   import common_pkg::*;

   localparam int unsigned MEM_RD_LAT_DEF      = 2;
   localparam int unsigned XBAR_LAT_DEF        = 1;
   localparam int unsigned ALU_LAT_PER_LVL_DEF = 1;

   typedef logic [N_BANKS-1:0]            reg_we_t;
   typedef logic [N_BANKS-1:0][SEL_W-1:0] reg_wr_sel_t;

   typedef enum logic [1:0] {
      ModeRam  = 2'd0,
      ModeXbar = 2'd1,
      ModeAlu  = 2'd2
   } reg_wr_mode_t;

   typedef struct packed {
      reg_we_t      we;
      reg_wr_sel_t  sel;
      reg_wr_mode_t mode;
   } wb_slot_t;

   localparam wb_slot_t SLOT_EMPTY = '{we: '0, sel: '0, mode: ModeRam};

endpackage

// File: rtl/wb_scheduler_if.sv
// Descriptor handshake between the instruction decoder and the write-back scheduler.
interface wb_scheduler_if;

   import instr_decd_pkg::*;

   logic         in_valid;
   logic         in_ready;
   reg_we_t      in_we;
   reg_wr_sel_t  in_sel;
   reg_wr_mode_t in_mode;

   modport master (output in_valid, in_we, in_sel, in_mode, input in_ready);
   modport slave  (input in_valid, in_we, in_sel, in_mode, output in_ready);

endinterface

// File: rtl/wb_lat_calc.sv
// Combinational latency and legality evaluation for one write-back descriptor.
module wb_lat_calc import common_pkg::*, instr_decd_pkg::*; #(
   parameter int unsigned MEM_RD_LAT      = MEM_RD_LAT_DEF,
   parameter int unsigned XBAR_LAT        = XBAR_LAT_DEF,
   parameter int unsigned ALU_LAT_PER_LVL = ALU_LAT_PER_LVL_DEF
) (
   input  reg_we_t      we,
   input  reg_wr_sel_t  sel,
   input  reg_wr_mode_t mode,
   output int unsigned  lat,
   output logic         reserve,
   output logic         illegal
);

   int unsigned max_sel;
   logic        bad_sel;

   always_comb begin
      max_sel = 0;
      bad_sel = 1'b0;
      for (int b = 0; b < N_BANKS; b++) begin
         if (we[b]) begin
            if (sel[b] == '0 || 32'(sel[b]) > TREE_DEPTH) bad_sel = 1'b1;
            if (32'(sel[b]) > max_sel) max_sel = 32'(sel[b]);
         end
      end

      lat     = 0;
      illegal = 1'b0;
      case (mode)
         ModeRam:  lat = MEM_RD_LAT;
         ModeXbar: lat = XBAR_LAT;
         ModeAlu: begin
            lat     = ALU_LAT_PER_LVL * max_sel;
            illegal = (|we) && bad_sel;
         end
         default:  lat = 0;
      endcase

      // Empty masks, illegal ALU trees and unknown modes are swallowed without a slot.
      reserve = (|we) && !illegal && (lat != 0);
   end

endmodule

// File: rtl/wb_scheduler.sv
// Write-back calendar: reserves register-file write slots L cycles ahead of each descriptor.
// Optional stall counter port stall_cnt is built only when WB_SCHED_STATS_EN is defined.
module wb_scheduler import common_pkg::*, instr_decd_pkg::*; #(
   parameter int unsigned MEM_RD_LAT      = MEM_RD_LAT_DEF,
   parameter int unsigned XBAR_LAT        = XBAR_LAT_DEF,
   parameter int unsigned ALU_LAT_PER_LVL = ALU_LAT_PER_LVL_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   wb_scheduler_if.slave dec,
   input  logic          flush,
   output reg_we_t       reg_we,
   output reg_wr_sel_t   reg_wr_sel,
   output reg_wr_mode_t  reg_wr_mode,
   output logic          busy,
   output logic          err_illegal
`ifdef WB_SCHED_STATS_EN
   ,
   output logic [31:0]   stall_cnt
`endif
);

   localparam int unsigned CAL_DEPTH = cal_depth(MEM_RD_LAT, XBAR_LAT, ALU_LAT_PER_LVL);

   wb_slot_t    cal_q   [CAL_DEPTH];
   wb_slot_t    cal_d   [CAL_DEPTH];
   wb_slot_t    shifted [CAL_DEPTH];
   wb_slot_t    tgt;
   logic        err_q;
   logic        ready;
   logic        accept;
   logic        compat;
   int unsigned lat;
   logic        reserve;
   logic        illegal;

   wb_lat_calc #(
      .MEM_RD_LAT      (MEM_RD_LAT),
      .XBAR_LAT        (XBAR_LAT),
      .ALU_LAT_PER_LVL (ALU_LAT_PER_LVL)
   ) u_lat_calc (
      .we      (dec.in_we),
      .sel     (dec.in_sel),
      .mode    (dec.in_mode),
      .lat     (lat),
      .reserve (reserve),
      .illegal (illegal)
   );

   // A descriptor accepted now lands in slot L-1 after this cycle's shift,
   // so compatibility is judged against the post-shift view of the calendar.
   always_comb begin
      for (int i = 0; i < CAL_DEPTH - 1; i++) shifted[i] = cal_q[i+1];
      shifted[CAL_DEPTH-1] = SLOT_EMPTY;

      tgt = SLOT_EMPTY;
      for (int i = 0; i < CAL_DEPTH; i++) begin
         if (lat == i + 1) tgt = shifted[i];
      end

      compat = (tgt.we == '0) ||
               ((tgt.mode == dec.in_mode) && ((tgt.we & dec.in_we) == '0));
      ready  = rst_n && !flush && (!reserve || compat);
      accept = dec.in_valid && ready;
   end

   always_comb begin
      cal_d = shifted;
      if (flush) begin
         for (int i = 0; i < CAL_DEPTH; i++) cal_d[i] = SLOT_EMPTY;
      end else if (accept && reserve) begin
         for (int i = 0; i < CAL_DEPTH; i++) begin
            if (lat == i + 1) begin
               cal_d[i].we   = shifted[i].we | dec.in_we;
               cal_d[i].mode = dec.in_mode;
               for (int b = 0; b < N_BANKS; b++) begin
                  if (dec.in_we[b]) cal_d[i].sel[b] = dec.in_sel[b];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CAL_DEPTH; i++) cal_q[i] <= SLOT_EMPTY;
         err_q <= 1'b0;
      end else begin
         cal_q <= cal_d;
         err_q <= accept && illegal;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < CAL_DEPTH; i++) busy = busy | (|cal_q[i].we);
   end

   assign dec.in_ready = ready;
   assign reg_we       = cal_q[0].we;
   assign reg_wr_sel   = cal_q[0].sel;
   assign reg_wr_mode  = cal_q[0].mode;
   assign err_illegal  = err_q;

`ifdef WB_SCHED_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (dec.in_valid && !ready && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule
